// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM input.
// The pin is synchronised and its edges detected. An optional prescaler
// sets the measurement tick rate. A three-state FSM times the high phase
// and the full period, then publishes both values with a one-cycle valid
// pulse. A sticky timeout flag reports a counter that saturated because
// the input stopped toggling.
`timescale 1ns/1ps

module pwm_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  control,
    input  logic        pwm_in,
    output logic [15:0] period,
    output logic [15:0] high_time,
    output logic        valid,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Control field decode
    logic       enable;
    logic       clear_flags;
    logic [2:0] prescale_sel;
    logic       reserved_unused;

    assign enable          = control[0];
    assign clear_flags     = control[1];
    assign reserved_unused = control[2];
    assign prescale_sel    = control[5:3];

    // Synchroniser chain and edge detection
    logic sync1_reg;
    logic sync2_reg;
    logic delayed_reg;
    logic rise;
    logic fall;

    // Two-flop synchroniser plus one delay flop for edge comparison
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            delayed_reg <= 1'b0;
        end else begin
            sync1_reg   <= pwm_in;
            sync2_reg   <= sync1_reg;
            delayed_reg <= sync2_reg;
        end
    end

    assign rise = sync2_reg & ~delayed_reg;
    assign fall = ~sync2_reg & delayed_reg;

    // Prescaler
    logic [12:0] div_m1;
    logic [12:0] pre_cnt_reg;
    logic [12:0] pre_cnt_next;
    logic        tick;

    // Decode the selected divide ratio into its terminal count (N-1)
    always_comb begin
        div_m1 = 13'd0;
        case (prescale_sel)
            3'd0: div_m1 = 13'd0;
            3'd1: div_m1 = 13'd7;
            3'd2: div_m1 = 13'd63;
            3'd3: div_m1 = 13'd255;
            3'd4: div_m1 = 13'd1023;
            3'd5: div_m1 = 13'd2047;
            3'd6: div_m1 = 13'd4095;
            3'd7: div_m1 = 13'd8191;
            default: div_m1 = 13'd0;
        endcase
    end

    // ">=" rather than "==" so a mid-run switch to a smaller ratio
    // recovers immediately instead of wrapping through all 8192 counts.
    assign tick = enable && (pre_cnt_reg >= div_m1);

    // Prescale counter next value: restart on rising edges so the
    // measurement windows line up with the waveform.
    always_comb begin
        pre_cnt_next = pre_cnt_reg + 13'd1;
        if (!enable || rise || tick) begin
            pre_cnt_next = 13'd0;
        end
    end

    // Prescale counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_reg <= 13'd0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
        end
    end

    // Measurement FSM
    state_t      state_reg;
    state_t      state_next;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic [15:0] hold_reg;
    logic [15:0] hold_next;
    logic [15:0] cnt_inc;
    logic        capture;
    logic        sat_set;

    // The count including this cycle's tick, saturating at the maximum
    assign cnt_inc = (tick && (cnt_reg != CNT_MAX)) ? (cnt_reg + 16'd1) : cnt_reg;

    // State, measure counter and held high count registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 16'd0;
            hold_reg  <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hold_reg  <= hold_next;
        end
    end

    // Next-state logic: edges take priority over saturation in each state
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hold_next  = hold_reg;
        capture    = 1'b0;
        sat_set    = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = 16'd0;
            hold_next  = 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_next = HIGH;
                        cnt_next   = 16'd0;
                    end
                end
                HIGH: begin
                    if (rise) begin
                        // Missed falling edge: restart without capturing
                        state_next = HIGH;
                        cnt_next   = 16'd0;
                    end else if (fall) begin
                        state_next = LOW;
                        hold_next  = cnt_inc;
                        cnt_next   = cnt_inc;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_next = IDLE;
                        cnt_next   = 16'd0;
                        sat_set    = 1'b1;
                    end else begin
                        cnt_next   = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_next = HIGH;
                        cnt_next   = 16'd0;
                        capture    = 1'b1;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_next = IDLE;
                        cnt_next   = 16'd0;
                        sat_set    = 1'b1;
                    end else begin
                        cnt_next   = cnt_inc;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end
            endcase
        end
    end

    // Result registers, valid pulse and sticky timeout (set beats clear)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period    <= 16'd0;
            high_time <= 16'd0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= capture;
            timeout <= sat_set | (timeout & ~clear_flags);
            if (capture) begin
                period    <= cnt_inc;
                high_time <= hold_reg;
            end
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven bench for pwm_capture.
`timescale 1ns/1ps

module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  control;
    logic        pwm_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        timeout;
    logic        busy;

    logic        pwm_drv = 1'b0;
    logic        gen_en  = 1'b0;
    logic        gen_out = 1'b0;
    logic [7:0]  gen_cnt = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pwm_capture dut (
        .clk       (clk),
        .reset     (reset),
        .control   (control),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign pwm_in = gen_en ? gen_out : pwm_drv;

    // 8-bit PWM generator, duty 64 of 256
    always @(negedge clk) begin
        if (gen_en) begin
            gen_out <= (gen_cnt < 8'd64);
            gen_cnt <= gen_cnt + 8'd1;
        end else begin
            gen_out <= 1'b0;
            gen_cnt <= 8'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Valid monitor: one line per capture
    int          valid_cnt = 0;
    logic        valid_prev = 1'b0;
    bit          mon_en = 1'b0;
    bit          lat_en = 1'b0;
    logic [15:0] exp_period = 16'd0;
    logic [15:0] exp_high   = 16'd0;
    int          rise_cyc   = 0;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            chk("valid_width", {31'd0, valid_prev}, 32'd0);
            if (mon_en) begin
                chk("cap_period", {16'd0, period}, {16'd0, exp_period});
                chk("cap_high", {16'd0, high_time}, {16'd0, exp_high});
            end
            if (lat_en) begin
                checks++;
                if ((cyc - rise_cyc) < 3 || (cyc - rise_cyc) > 4) begin
                    errors++;
                    $display("FAIL latency: got %0d clk expected 3..4", cyc - rise_cyc);
                end
            end
        end
        valid_prev <= valid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive nper periods then one more rising edge to close the last period
    task automatic drive_wave(input int per, input int hi, input int nper);
        for (int p = 0; p < nper; p++) begin
            pwm_drv  = 1'b1;
            rise_cyc = cyc;
            wait_clks(hi);
            pwm_drv  = 1'b0;
            wait_clks(per - hi);
        end
        pwm_drv  = 1'b1;
        rise_cyc = cyc;
        wait_clks(6);
        pwm_drv  = 1'b0;
        wait_clks(4);
    endtask

    typedef struct {
        int          per;
        int          hi;
        logic [2:0]  sel;
        logic [15:0] exp_p;
        logic [15:0] exp_h;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;

        vecs[0] = '{per: 100, hi: 25,  sel: 3'd0, exp_p: 16'd100, exp_h: 16'd25};
        vecs[1] = '{per: 800, hi: 400, sel: 3'd1, exp_p: 16'd100, exp_h: 16'd50};
        vecs[2] = '{per: 64,  hi: 32,  sel: 3'd0, exp_p: 16'd64,  exp_h: 16'd32};
        vecs[3] = '{per: 20,  hi: 1,   sel: 3'd0, exp_p: 16'd20,  exp_h: 16'd1};
        vecs[4] = '{per: 300, hi: 299, sel: 3'd0, exp_p: 16'd300, exp_h: 16'd299};
        vecs[5] = '{per: 640, hi: 192, sel: 3'd2, exp_p: 16'd10,  exp_h: 16'd3};

        // Reset state
        reset   = 1'b1;
        control = 6'd0;
        wait_clks(3);
        chk("rst_period", {16'd0, period}, 32'd0);
        chk("rst_high", {16'd0, high_time}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_clks(2);

        // Table-driven captures
        for (int i = 0; i < 6; i++) begin
            control = 6'd0;
            wait_clks(3);
            control = {vecs[i].sel, 3'b001};
            wait_clks(2);
            exp_period = vecs[i].exp_p;
            exp_high   = vecs[i].exp_h;
            mon_en = 1'b1;
            lat_en = 1'b1;
            v0 = valid_cnt;
            drive_wave(vecs[i].per, vecs[i].hi, 3);
            chk("vec_valids", valid_cnt - v0, 32'd3);
            mon_en = 1'b0;
            lat_en = 1'b0;
        end

        // Timeout on a stuck-high input
        control = 6'd0;
        wait_clks(3);
        control = 6'b000001;
        wait_clks(2);
        v0 = valid_cnt;
        pwm_drv = 1'b1;
        wait_clks(70000);
        chk("to_no_valid", valid_cnt - v0, 32'd0);
        chk("to_timeout", {31'd0, timeout}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_period_hold", {16'd0, period}, 32'd10);
        chk("to_high_hold", {16'd0, high_time}, 32'd3);
        control = 6'b000011;
        wait_clks(1);
        control = 6'b000001;
        chk("to_cleared", {31'd0, timeout}, 32'd0);
        pwm_drv = 1'b0;
        wait_clks(5);

        // Disable mid-period
        control = 6'd0;
        wait_clks(3);
        control = 6'b000001;
        wait_clks(2);
        v0 = valid_cnt;
        pwm_drv = 1'b1;
        wait_clks(25);
        pwm_drv = 1'b0;
        wait_clks(10);
        chk("dis_busy_low_phase", {31'd0, busy}, 32'd1);
        control = 6'd0;
        wait_clks(1);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        chk("dis_period_hold", {16'd0, period}, 32'd10);
        chk("dis_high_hold", {16'd0, high_time}, 32'd3);
        wait_clks(5);
        control = 6'b000001;
        wait_clks(60);
        pwm_drv  = 1'b1;
        rise_cyc = cyc;
        wait_clks(25);
        pwm_drv = 1'b0;
        wait_clks(75);
        chk("reen_no_early_valid", valid_cnt - v0, 32'd0);
        exp_period = 16'd100;
        exp_high   = 16'd25;
        mon_en = 1'b1;
        lat_en = 1'b1;
        pwm_drv  = 1'b1;
        rise_cyc = cyc;
        wait_clks(6);
        pwm_drv = 1'b0;
        chk("reen_one_valid", valid_cnt - v0, 32'd1);
        mon_en = 1'b0;
        lat_en = 1'b0;
        wait_clks(4);

        // Reset during HIGH
        control = 6'd0;
        wait_clks(3);
        control = 6'b000001;
        wait_clks(2);
        pwm_drv = 1'b1;
        wait_clks(10);
        chk("rh_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rh_period", {16'd0, period}, 32'd0);
        chk("rh_high", {16'd0, high_time}, 32'd0);
        chk("rh_valid", {31'd0, valid}, 32'd0);
        chk("rh_timeout", {31'd0, timeout}, 32'd0);
        chk("rh_busy0", {31'd0, busy}, 32'd0);
        pwm_drv = 1'b0;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);
        exp_period = 16'd64;
        exp_high   = 16'd32;
        mon_en = 1'b1;
        v0 = valid_cnt;
        drive_wave(64, 32, 3);
        chk("rh_valids", valid_cnt - v0, 32'd3);
        mon_en = 1'b0;

        // Loopback against the 8-bit PWM generator
        control = 6'd0;
        wait_clks(3);
        control = 6'b000001;
        wait_clks(2);
        exp_period = 16'd256;
        exp_high   = 16'd64;
        mon_en = 1'b1;
        v0 = valid_cnt;
        gen_en = 1'b1;
        wait_clks(256 * 4 + 128);
        gen_en = 1'b0;
        chk("gen_valids", valid_cnt - v0, 32'd4);
        mon_en = 1'b0;
        wait_clks(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
